// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, even parity, one stop bit, with a
// one-entry holding buffer so consecutive frames can run with no idle gap.
module uart_tx #(
  parameter int unsigned BR_count_width  = 5,
  parameter int unsigned BR_clock_cycles = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       TX_en,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [BR_count_width-1:0] BIT_LAST = BR_count_width'(BR_clock_cycles - 1);

  logic [2:0]                r_state, w_state_d;
  logic [BR_count_width-1:0] r_count, w_count_d;
  logic [2:0]                r_idx, w_idx_d;
  logic [7:0]                r_shift, w_shift_d;
  logic                      r_parity, w_parity_d;
  logic [7:0]                r_buf, w_buf_d;
  logic                      r_buf_full, w_buf_full_d;
  logic                      r_tx, w_tx_d;

  logic       w_bit_trig;
  logic       w_accept;
  logic       w_end_of_stop;
  logic       w_start_frame;
  logic [7:0] w_load_byte;

  assign busy          = (r_state != S_IDLE);
  assign w_bit_trig    = busy && (r_count == BIT_LAST);
  assign ready         = TX_en && !r_buf_full;
  assign w_accept      = data_valid && ready;
  assign w_end_of_stop = (r_state == S_STOP) && w_bit_trig;
  assign tx_done       = w_end_of_stop;
  assign TX            = r_tx;

  // A held byte always wins at end of stop; ready is low while the buffer is full.
  assign w_start_frame = ((r_state == S_IDLE) && w_accept) ||
                         (w_end_of_stop && (r_buf_full || w_accept));
  assign w_load_byte   = r_buf_full ? r_buf : data_in;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_idx_d      = r_idx;
    w_shift_d    = r_shift;
    w_parity_d   = r_parity;
    w_buf_d      = r_buf;
    w_buf_full_d = r_buf_full;

    if (busy) begin
      w_count_d = w_bit_trig ? '0 : r_count + 1'b1;
    end

    case (r_state)
      S_IDLE: ;
      S_START: begin
        if (w_bit_trig) begin
          w_state_d = S_DATA;
          w_idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_trig) begin
          if (r_idx == 3'd7) begin
            w_state_d = S_PARITY;
          end else begin
            w_shift_d = {1'b0, r_shift[7:1]};
            w_idx_d   = r_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_trig) w_state_d = S_STOP;
      end
      S_STOP: begin
        if (w_bit_trig) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase

    if (w_start_frame) begin
      w_state_d  = S_START;
      w_count_d  = '0;
      w_idx_d    = 3'd0;
      w_shift_d  = w_load_byte;
      w_parity_d = ^w_load_byte;
    end

    if (w_end_of_stop && r_buf_full) begin
      w_buf_full_d = 1'b0;
    end else if (w_accept && busy && !w_end_of_stop) begin
      w_buf_d      = data_in;
      w_buf_full_d = 1'b1;
    end

    case (w_state_d)
      S_START:  w_tx_d = 1'b0;
      S_DATA:   w_tx_d = w_shift_d[0];
      S_PARITY: w_tx_d = w_parity_d;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_buf      <= 8'd0;
      r_buf_full <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_idx      <= w_idx_d;
      r_shift    <= w_shift_d;
      r_parity   <= w_parity_d;
      r_buf      <= w_buf_d;
      r_buf_full <= w_buf_full_d;
      r_tx       <= w_tx_d;
    end
  end

endmodule
